// File: rtl/router_read_scheduler.sv
// router_read_scheduler: drains the 1x3 router FIFOs round-robin, one whole packet at a time,
// into one sop/eop-framed byte stream. Build macro PARITY_CHECK_EN adds an eop-beat parity check.
//   state | meaning
//   IDLE  | no read issued; grant the next requester after ptr
//   XFER  | reading the granted port until its parity beat lands
module router_read_scheduler #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_WAIT   = 30
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vld_out_0,
    input  logic                  vld_out_1,
    input  logic                  vld_out_2,
    input  logic [DATA_WIDTH-1:0] data_out_0,
    input  logic [DATA_WIDTH-1:0] data_out_1,
    input  logic [DATA_WIDTH-1:0] data_out_2,
    output logic                  read_enb_0,
    output logic                  read_enb_1,
    output logic                  read_enb_2,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_sop,
    output logic                  m_eop,
    output logic [1:0]            m_port,
    output logic                  m_parity_err,
    output logic [2:0]            starve_err
);
    typedef enum logic {IDLE, XFER} state_t;

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_TOP = WW'(MAX_WAIT);
    localparam logic [WW-1:0] WAIT_PRE = WW'(MAX_WAIT - 1);

    state_t                state, state_next;
    logic [1:0]            grant, grant_next, ptr, pick, cand_a, cand_b;
    logic                  grant_take;
    logic [6:0]            issued, total, landed;
    logic                  inflight, rd_go, space_ok;
    logic                  push, pop, push_sop, push_eop;
    logic [2:0]            vld, starving;
    logic [2:0]            level;
    logic [DATA_WIDTH-1:0] push_data;
    logic [DATA_WIDTH-1:0] buf_data [2];
    logic [1:0]            buf_port [2];
    logic [1:0]            buf_sop, buf_eop;
    logic                  wr_ptr, rd_ptr;
    logic [1:0]            occ;
    logic [WW-1:0]         wait_cnt [3];

    assign vld = {vld_out_2, vld_out_1, vld_out_0};

    function automatic logic [1:0] succ(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    always_comb begin
        cand_a = succ(ptr);
        cand_b = succ(cand_a);
        if (vld[cand_a])      pick = cand_a;
        else if (vld[cand_b]) pick = cand_b;
        else                  pick = succ(cand_b);
    end

    always_comb begin
        push_data = data_out_0;
        case (grant)
            2'd1:    push_data = data_out_1;
            2'd2:    push_data = data_out_2;
            default: push_data = data_out_0;
        endcase
    end

    // A pop in the same cycle frees a slot, which keeps reads back-to-back under m_ready=1.
    assign level    = {1'b0, occ} + {2'b00, inflight};
    assign pop      = m_valid && m_ready;
    assign space_ok = (level < 3'd2) || (level == 3'd2 && pop);
    assign rd_go    = !reset && (state == XFER) && vld[grant] && (issued < total) && space_ok;

    assign push     = inflight;
    assign push_sop = (landed == 7'd0);
    assign push_eop = (landed != 7'd0) && ((landed + 7'd1) == total);

    always_comb begin
        state_next = state;
        grant_next = grant;
        grant_take = 1'b0;
        case (state)
            IDLE: begin
                if (|vld) begin
                    grant_take = 1'b1;
                    grant_next = pick;
                    state_next = XFER;
                end
            end
            XFER: begin
                if (push && push_eop) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= 2'd0;
            ptr      <= 2'd0;
            issued   <= 7'd0;
            total    <= 7'd2;
            landed   <= 7'd0;
            inflight <= 1'b0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            occ      <= 2'd0;
        end else begin
            state    <= state_next;
            grant    <= grant_next;
            inflight <= rd_go;
            if (grant_take) begin
                issued <= 7'd0;
                total  <= 7'd2;
                landed <= 7'd0;
            end else begin
                if (rd_go) issued <= issued + 7'd1;
                if (push) begin
                    landed <= landed + 7'd1;
                    if (push_sop) total <= {1'b0, push_data[7:2]} + 7'd2;
                end
            end
            if (push && push_eop) ptr <= grant;
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // Storage needs no reset: the pointers and occ decide what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_data[wr_ptr] <= push_data;
            buf_port[wr_ptr] <= grant;
            buf_sop[wr_ptr]  <= push_sop;
            buf_eop[wr_ptr]  <= push_eop;
        end
    end

    assign m_valid = (occ != 2'd0);
    assign m_data  = m_valid ? buf_data[rd_ptr] : '0;
    assign m_port  = m_valid ? buf_port[rd_ptr] : 2'd0;
    assign m_sop   = m_valid && buf_sop[rd_ptr];
    assign m_eop   = m_valid && buf_eop[rd_ptr];

    assign read_enb_0 = rd_go && (grant == 2'd0);
    assign read_enb_1 = rd_go && (grant == 2'd1);
    assign read_enb_2 = rd_go && (grant == 2'd2);

`ifdef PARITY_CHECK_EN
    logic [DATA_WIDTH-1:0] par_acc;
    logic [1:0]            buf_perr;

    always_ff @(posedge clk) begin
        if (reset)                  par_acc <= '0;
        else if (grant_take)        par_acc <= '0;
        else if (push && !push_eop) par_acc <= par_acc ^ push_data;
    end

    always_ff @(posedge clk) begin
        if (push) buf_perr[wr_ptr] <= push_eop && (par_acc != push_data);
    end

    assign m_parity_err = m_valid && buf_eop[rd_ptr] && buf_perr[rd_ptr];
`else
    assign m_parity_err = 1'b0;
`endif

    always_comb begin
        starving = 3'b000;
        for (int k = 0; k < 3; k++)
            starving[k] = vld[k] && !((state == XFER) && (grant == 2'(k)));
    end

    // Counter saturates at MAX_WAIT so the pulse fires once per continuous wait.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_err <= 3'b000;
            for (int k = 0; k < 3; k++) wait_cnt[k] <= '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                starve_err[k] <= starving[k] && (wait_cnt[k] == WAIT_PRE);
                if (!starving[k])               wait_cnt[k] <= '0;
                else if (wait_cnt[k] != WAIT_TOP) wait_cnt[k] <= wait_cnt[k] + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_router_read_scheduler.sv
// Bench for router_read_scheduler: router FIFO models feed the DUT, expected beats are queued
// at packet load time and compared against beats captured at the output handshake.
module tb_router_read_scheduler;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       vld_out_0 = 1'b0, vld_out_1 = 1'b0, vld_out_2 = 1'b0;
    logic [7:0] data_out_0 = 8'h00, data_out_1 = 8'h00, data_out_2 = 8'h00;
    logic       read_enb_0, read_enb_1, read_enb_2;
    logic [7:0] m_data;
    logic       m_valid, m_sop, m_eop, m_parity_err;
    logic       m_ready = 1'b1;
    logic [1:0] m_port;
    logic [2:0] starve_err;

    always #5 clk = ~clk;

    router_read_scheduler #(.DATA_WIDTH(8), .MAX_WAIT(30)) dut (
        .clk(clk), .reset(reset),
        .vld_out_0(vld_out_0), .vld_out_1(vld_out_1), .vld_out_2(vld_out_2),
        .data_out_0(data_out_0), .data_out_1(data_out_1), .data_out_2(data_out_2),
        .read_enb_0(read_enb_0), .read_enb_1(read_enb_1), .read_enb_2(read_enb_2),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_sop(m_sop), .m_eop(m_eop), .m_port(m_port),
        .m_parity_err(m_parity_err), .starve_err(starve_err)
    );

    logic [7:0]  rq0[$], rq1[$], rq2[$];
    logic [2:0]  hold = 3'b000;
    logic [12:0] exp_q[$], obs_q[$];
    int total = 0, bad = 0;
    int proto_err = 0, rd_cnt = 0, pop_cnt = 0;
    int starve_seen[3] = '{0, 0, 0};
    int rd_seen[3] = '{0, 0, 0};
    logic       prev_stall = 1'b0;
    logic [12:0] prev_beat = '0;

    // Router FIFO model: registered read data, vld refreshed just after the edge.
    always @(posedge clk) begin
        if (read_enb_0 && rq0.size() != 0) data_out_0 <= rq0.pop_front();
        if (read_enb_1 && rq1.size() != 0) data_out_1 <= rq1.pop_front();
        if (read_enb_2 && rq2.size() != 0) data_out_2 <= rq2.pop_front();
        #1;
        vld_out_0 = (rq0.size() != 0) && !hold[0];
        vld_out_1 = (rq1.size() != 0) && !hold[1];
        vld_out_2 = (rq2.size() != 0) && !hold[2];
    end

    // Monitor: capture accepted beats, tally protocol violations and pulses.
    always @(negedge clk) begin
        logic [12:0] beat;
        beat = {m_eop ? m_parity_err : 1'b0, m_port, m_eop, m_sop, m_data};
        if (reset) begin
            rd_cnt = 0; pop_cnt = 0; prev_stall = 1'b0;
        end else begin
            if (int'(read_enb_0) + int'(read_enb_1) + int'(read_enb_2) > 1) proto_err++;
            if ((read_enb_0 && !vld_out_0) || (read_enb_1 && !vld_out_1) || (read_enb_2 && !vld_out_2))
                proto_err++;
            if (prev_stall && (!m_valid || beat != prev_beat)) proto_err++;
            rd_cnt += int'(read_enb_0) + int'(read_enb_1) + int'(read_enb_2);
            if (read_enb_0) rd_seen[0]++;
            if (read_enb_1) rd_seen[1]++;
            if (read_enb_2) rd_seen[2]++;
            if (m_valid && m_ready) begin
                obs_q.push_back(beat);
                pop_cnt++;
            end
            if (rd_cnt - pop_cnt > 2) proto_err++;
            prev_stall = m_valid && !m_ready;
            prev_beat  = beat;
            for (int k = 0; k < 3; k++) if (starve_err[k]) starve_seen[k]++;
        end
    end

    task automatic load_pkt(input int port, input int len, input logic [1:0] addr, input bit corrupt);
        logic [7:0] pk[$];
        logic [7:0] b, par;
        logic       perr;
        b = {6'(len), addr};
        par = b;
        pk.push_back(b);
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            par ^= b;
            pk.push_back(b);
        end
        pk.push_back(corrupt ? (par ^ 8'h5a) : par);
        for (int i = 0; i < pk.size(); i++) begin
            case (port)
                0: rq0.push_back(pk[i]);
                1: rq1.push_back(pk[i]);
                default: rq2.push_back(pk[i]);
            endcase
`ifdef PARITY_CHECK_EN
            perr = corrupt && (i == pk.size() - 1);
`else
            perr = 1'b0;
`endif
            exp_q.push_back({perr, 2'(port), i == pk.size() - 1, i == 0, pk[i]});
        end
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (obs_q.size() >= exp_q.size()) begin ok = 1'b1; break; end
        end
        repeat (4) @(posedge clk);
    endtask

    task automatic test_reset;
        logic [19:0] outs;
        m_ready = 1'b1;
        reset = 1'b1;
        load_pkt(1, 3, 2'b01, 0);
        load_pkt(2, 4, 2'b10, 0);
        load_pkt(0, 2, 2'b11, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            outs = {read_enb_2, read_enb_1, read_enb_0, m_valid, m_sop, m_eop, m_port,
                    m_parity_err, starve_err, m_data};
            total++;
            if (outs !== 20'd0) begin bad++; $display("FAIL reset_outs got=%h want=0", outs); end
        end
    endtask

    task automatic test_round_robin;
        bit ok;
        logic [12:0] e, o;
        @(posedge clk); #2 reset = 1'b0;
        wait_drain(300, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL rr_timeout got=%0d beats want=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL rr_beat got=none want=%h", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin bad++; $display("FAIL rr_beat got=%h want=%h", o, e); end
            end
        end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL rr_extra got=%0d want=0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_single_packet;
        int cyc = 0, first = -1, last = -1, n = 0;
        logic [12:0] e, o;
        load_pkt(1, 8, 2'b10, 0);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (read_enb_1) begin if (first < 0) first = c; last = c; n++; end
            if (obs_q.size() >= exp_q.size()) break;
        end
        repeat (4) @(posedge clk);
        total++;
        if (n != 10) begin bad++; $display("FAIL single_reads got=%0d want=10", n); end
        total++;
        if (last - first != 9) begin bad++; $display("FAIL single_consecutive got=%0d want=9", last - first); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL single_beat got=none want=%h", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin bad++; $display("FAIL single_beat got=%h want=%h", o, e); end
            end
        end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL single_extra got=%0d want=0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_stall_starve;
        int s0[3], r2, n = 0, low = 0, stall_rd = 0;
        bit ok;
        logic [12:0] e, o;
        s0 = starve_seen;
        r2 = rd_seen[2];
        load_pkt(2, 30, 2'b00, 0);
        load_pkt(0, 2, 2'b01, 0);
        for (int c = 0; c < 200 && n < 10; c++) begin
            @(negedge clk);
            if (read_enb_2) n++;
        end
        @(posedge clk); #2 hold[2] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (!vld_out_2) begin low++; if (read_enb_2) stall_rd++; end
        end
        @(posedge clk); #2 hold[2] = 1'b0;
        wait_drain(300, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL stall_timeout got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        total++;
        if (low < 3 || stall_rd != 0) begin bad++; $display("FAIL stall_pause got=%0d low/%0d reads want>=3/0", low, stall_rd); end
        total++;
        if (rd_seen[2] - r2 != 32) begin bad++; $display("FAIL stall_reads got=%0d want=32", rd_seen[2] - r2); end
        total++;
        if (starve_seen[0] - s0[0] != 1) begin bad++; $display("FAIL starve0 got=%0d want=1", starve_seen[0] - s0[0]); end
        total++;
        if (starve_seen[1] - s0[1] != 0 || starve_seen[2] - s0[2] != 0) begin
            bad++; $display("FAIL starve12 got=%0d/%0d want=0/0", starve_seen[1] - s0[1], starve_seen[2] - s0[2]);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL stall_beat got=none want=%h", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin bad++; $display("FAIL stall_beat got=%h want=%h", o, e); end
            end
        end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL stall_extra got=%0d want=0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_backpressure;
        bit ok = 1'b0;
        logic [12:0] e, o;
        load_pkt(0, 5, 2'b10, 0);
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #2 m_ready = ~m_ready;
            if (obs_q.size() >= exp_q.size()) begin ok = 1'b1; break; end
        end
        m_ready = 1'b1;
        repeat (4) @(posedge clk);
        total++;
        if (!ok) begin bad++; $display("FAIL bp_timeout got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        total++;
        if (proto_err !== 0) begin bad++; $display("FAIL bp_protocol got=%0d want=0", proto_err); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL bp_beat got=none want=%h", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin bad++; $display("FAIL bp_beat got=%h want=%h", o, e); end
            end
        end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL bp_extra got=%0d want=0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_parity;
        bit ok;
        logic [12:0] e, o;
        load_pkt(1, 4, 2'b01, 1);
        load_pkt(2, 6, 2'b11, 0);
        wait_drain(300, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL parity_timeout got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL parity_beat got=none want=%h", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin bad++; $display("FAIL parity_beat got=%h want=%h", o, e); end
            end
        end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL parity_extra got=%0d want=0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_length_bounds;
        int r0, r1;
        bit ok;
        logic [12:0] e, o;
        r0 = rd_seen[0];
        r1 = rd_seen[1];
        load_pkt(0, 0, 2'b00, 0);
        load_pkt(1, 63, 2'b10, 0);
        wait_drain(400, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL len_timeout got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        total++;
        if (rd_seen[0] - r0 != 2) begin bad++; $display("FAIL len0_reads got=%0d want=2", rd_seen[0] - r0); end
        total++;
        if (rd_seen[1] - r1 != 65) begin bad++; $display("FAIL len63_reads got=%0d want=65", rd_seen[1] - r1); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL len_beat got=none want=%h", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin bad++; $display("FAIL len_beat got=%h want=%h", o, e); end
            end
        end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL len_extra got=%0d want=0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_reset_mid_packet;
        bit ok;
        logic [4:0] outs;
        logic [12:0] e, o;
        load_pkt(2, 20, 2'b01, 0);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (obs_q.size() >= 3) break;
        end
        @(posedge clk); #2 reset = 1'b1;
        rq2.delete();
        exp_q.delete();
        obs_q.delete();
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            outs = {read_enb_2, read_enb_1, read_enb_0, m_valid, m_eop};
            total++;
            if (outs !== 5'd0) begin bad++; $display("FAIL midrst_outs got=%b want=00000", outs); end
        end
        @(posedge clk); #2 reset = 1'b0;
        repeat (10) @(posedge clk);
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL midrst_stray got=%0d beats want=0", obs_q.size()); obs_q.delete(); end
        // ptr is back to 0 after reset, so port1 must win over port2.
        load_pkt(1, 3, 2'b00, 0);
        load_pkt(2, 2, 2'b11, 0);
        wait_drain(300, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL midrst_timeout got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) begin bad++; $display("FAIL midrst_beat got=none want=%h", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin bad++; $display("FAIL midrst_beat got=%h want=%h", o, e); end
            end
        end
        total++;
        if (proto_err !== 0) begin bad++; $display("FAIL protocol got=%0d want=0", proto_err); end
    endtask

    initial begin
        test_reset;
        test_round_robin;
        test_single_packet;
        test_stall_starve;
        test_backpressure;
        test_parity;
        test_length_bounds;
        test_reset_mid_packet;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
